// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port data SRAM among NREQ lanes.
// Grant and SRAM access happen in the same cycle; read data returns one cycle later.
module sram_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 14,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wd,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [DW-1:0]        rdata,
    output logic [AW-1:0]        sram_addr,
    output logic                 sram_we,
    output logic [DW-1:0]        sram_wd,
    input  logic [DW-1:0]        sram_rd
);

    localparam int PW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    logic [PW-1:0] ptr;
    logic [PW-1:0] lock_owner;
    logic          lock_valid;

    logic [PW-1:0] win;
    logic [PW-1:0] nxt_ptr;
    logic [PW:0]   idx;
    logic          has_win;
    logic          lock_path;

    // Reset suppresses any winner so nothing reaches the SRAM or the read path.
    always_comb begin
        win       = '0;
        has_win   = 1'b0;
        lock_path = 1'b0;
        idx       = '0;
        if (!reset) begin
            if (lock_valid && req[lock_owner]) begin
                win       = lock_owner;
                has_win   = 1'b1;
                lock_path = 1'b1;
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    idx = {1'b0, ptr} + (PW+1)'(i);
                    if (idx >= (PW+1)'(NREQ)) begin
                        idx = idx - (PW+1)'(NREQ);
                    end
                    if (!has_win && req[idx[PW-1:0]]) begin
                        win     = idx[PW-1:0];
                        has_win = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        nxt_ptr = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
    end

    always_comb begin
        gnt       = '0;
        sram_addr = '0;
        sram_wd   = '0;
        sram_we   = 1'b0;
        if (has_win) begin
            gnt       = ONE << win;
            sram_addr = req_addr[int'(win)*AW +: AW];
            sram_wd   = req_wd[int'(win)*DW +: DW];
            sram_we   = req_we[win];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            lock_valid <= 1'b0;
            lock_owner <= '0;
            rvalid     <= '0;
            rdata      <= '0;
        end else begin
            rvalid <= '0;
            if (has_win) begin
                if (!lock_path) begin
                    ptr <= nxt_ptr;
                end
                lock_valid <= req_lock[win];
                lock_owner <= win;
                if (!req_we[win]) begin
                    rvalid <= ONE << win;
                    rdata  <= sram_rd;
                end
            end else begin
                lock_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM and a queue-based scoreboard.
module tb_sram_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 14;
    localparam int DW   = 32;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_we;
    logic [NREQ-1:0]      req_lock;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wd;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rvalid;
    logic [DW-1:0]        rdata;
    logic [AW-1:0]        sram_addr;
    logic                 sram_we;
    logic [DW-1:0]        sram_wd;
    logic [DW-1:0]        sram_rd;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    typedef struct {
        logic [NREQ-1:0] g;
        logic            we;
        logic [AW-1:0]   a;
    } gexp_t;

    typedef struct {
        int            lane;
        logic [DW-1:0] data;
        int            due;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    int total = 0;
    int bad   = 0;
    int cnt   = 0;

    sram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wd    (req_wd),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .sram_addr (sram_addr),
        .sram_we   (sram_we),
        .sram_wd   (sram_wd),
        .sram_rd   (sram_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_wd;
        cnt <= cnt + 1;
    end
    assign sram_rd = mem[sram_addr];

    // Monitor: one grant expectation per driven cycle, one read expectation per rvalid pulse.
    always @(negedge clk) begin
        gexp_t ge;
        rexp_t re;
        logic [NREQ-1:0] oh;
        if (gq.size() > 0) begin
            ge = gq.pop_front();
            total++;
            if (gnt !== ge.g || sram_we !== ge.we || sram_addr !== ge.a) begin
                bad++;
                $display("FAIL grant @%0d: gnt=%b we=%b addr=%h, required gnt=%b we=%b addr=%h",
                         cnt, gnt, sram_we, sram_addr, ge.g, ge.we, ge.a);
            end
        end
        if (rvalid !== '0) begin
            total++;
            if (rq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rvalid @%0d: rvalid=%b rdata=%h, required none", cnt, rvalid, rdata);
            end else begin
                re = rq.pop_front();
                oh = 4'b0001 << re.lane;
                if (rvalid !== oh || rdata !== re.data || cnt != re.due) begin
                    bad++;
                    $display("FAIL read_return @%0d: rvalid=%b rdata=%h, required rvalid=%b rdata=%h at %0d",
                             cnt, rvalid, rdata, oh, re.data, re.due);
                end
            end
        end
    end

    task automatic set_lane(input int l, input logic we, input logic lk,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[l]               = 1'b1;
        req_we[l]            = we;
        req_lock[l]          = lk;
        req_addr[l*AW +: AW] = a;
        req_wd[l*DW +: DW]   = d;
    endtask

    task automatic drop(input int l);
        req[l]      = 1'b0;
        req_we[l]   = 1'b0;
        req_lock[l] = 1'b0;
    endtask

    task automatic clear_all();
        req      = '0;
        req_we   = '0;
        req_lock = '0;
    endtask

    task automatic expect_read(input int l, input logic [DW-1:0] d);
        rexp_t re;
        re.lane = l;
        re.data = d;
        re.due  = cnt + 1;
        rq.push_back(re);
    endtask

    task automatic step(input logic [NREQ-1:0] g, input logic we, input logic [AW-1:0] a);
        gexp_t ge;
        ge.g  = g;
        ge.we = we;
        ge.a  = a;
        gq.push_back(ge);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_we   = '0;
        req_lock = '0;
        req_addr = '0;
        req_wd   = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (gnt !== '0 || rvalid !== '0 || rdata !== '0) begin
            bad++;
            $display("FAIL reset_state: gnt=%b rvalid=%b rdata=%h, required all zero", gnt, rvalid, rdata);
        end
        reset = 1'b0;

        // Write then read-back on lane 2 (ptr 0 -> 3)
        clear_all();
        set_lane(2, 1'b1, 1'b0, 14'h0010, 32'hDEADBEEF);
        step(4'b0100, 1'b1, 14'h0010);
        set_lane(2, 1'b0, 1'b0, 14'h0010, 32'h0);
        expect_read(2, 32'hDEADBEEF);
        step(4'b0100, 1'b0, 14'h0010);

        // Preload addr i with 0xA0+i from lane i (ptr 3 -> 1 -> 2 -> 3 -> 0)
        for (int i = 0; i < 4; i++) begin
            clear_all();
            set_lane(i, 1'b1, 1'b0, AW'(i), DW'(32'hA0 + i));
            step(4'b0001 << i, 1'b1, AW'(i));
        end

        // All lanes reading continuously: strict rotation
        clear_all();
        for (int i = 0; i < 4; i++) set_lane(i, 1'b0, 1'b0, AW'(i), 32'h0);
        for (int k = 0; k < 8; k++) begin
            expect_read(k % 4, DW'(32'hA0 + (k % 4)));
            step(4'b0001 << (k % 4), 1'b0, AW'(k % 4));
        end

        // Lock sequence on lane 1 (set ptr to 1 first)
        clear_all();
        set_lane(0, 1'b1, 1'b0, 14'h0020, 32'h55);
        step(4'b0001, 1'b1, 14'h0020);
        clear_all();
        set_lane(0, 1'b0, 1'b0, 14'h0000, 32'h0);
        set_lane(3, 1'b0, 1'b0, 14'h0003, 32'h0);
        set_lane(1, 1'b0, 1'b1, 14'h0020, 32'h0);
        expect_read(1, 32'h55);
        step(4'b0010, 1'b0, 14'h0020);
        set_lane(1, 1'b1, 1'b1, 14'h0020, 32'hCAFE0001);
        step(4'b0010, 1'b1, 14'h0020);
        set_lane(1, 1'b0, 1'b1, 14'h0020, 32'h0);
        expect_read(1, 32'hCAFE0001);
        step(4'b0010, 1'b0, 14'h0020);
        drop(1);
        expect_read(3, 32'hA3);
        step(4'b1000, 1'b0, 14'h0003);
        drop(3);
        expect_read(0, 32'hA0);
        step(4'b0001, 1'b0, 14'h0000);

        // Idle, then a lone request is granted immediately
        clear_all();
        repeat (5) step(4'b0000, 1'b0, 14'h0000);
        set_lane(3, 1'b0, 1'b0, 14'h0003, 32'h0);
        expect_read(3, 32'hA3);
        step(4'b1000, 1'b0, 14'h0003);

        // Reset during a write and a pending read (ptr 0 -> 2 before reset)
        clear_all();
        set_lane(1, 1'b1, 1'b0, 14'h0005, 32'h5555);
        step(4'b0010, 1'b1, 14'h0005);
        clear_all();
        set_lane(0, 1'b1, 1'b0, 14'h0005, 32'h1234);
        set_lane(1, 1'b0, 1'b0, 14'h0001, 32'h0);
        reset = 1'b1;
        step(4'b0000, 1'b0, 14'h0000);
        reset = 1'b0;
        clear_all();
        set_lane(1, 1'b0, 1'b0, 14'h0005, 32'h0);
        set_lane(3, 1'b0, 1'b0, 14'h0003, 32'h0);
        expect_read(1, 32'h5555);
        step(4'b0010, 1'b0, 14'h0005);
        drop(1);
        expect_read(3, 32'hA3);
        step(4'b1000, 1'b0, 14'h0003);

        // Locked lane 0 drops req: lane 2 wins at once and the lock is gone
        clear_all();
        set_lane(0, 1'b0, 1'b1, 14'h0000, 32'h0);
        set_lane(2, 1'b0, 1'b0, 14'h0002, 32'h0);
        expect_read(0, 32'hA0);
        step(4'b0001, 1'b0, 14'h0000);
        drop(0);
        expect_read(2, 32'hA2);
        step(4'b0100, 1'b0, 14'h0002);
        set_lane(3, 1'b0, 1'b0, 14'h0003, 32'h0);
        expect_read(3, 32'hA3);
        step(4'b1000, 1'b0, 14'h0003);
        drop(3);
        expect_read(2, 32'hA2);
        step(4'b0100, 1'b0, 14'h0002);

        clear_all();
        step(4'b0000, 1'b0, 14'h0000);
        step(4'b0000, 1'b0, 14'h0000);

        total++;
        if (rq.size() != 0 || gq.size() != 0) begin
            bad++;
            $display("FAIL drain: pending reads=%0d grants=%0d, required 0 and 0", rq.size(), gq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Round-robin arbiter that shares the single-port 16K-word data SRAM among NREQ SIMT lane requesters.
- Exactly one lane reaches the SRAM port per cycle.
- Grant is issued in the same cycle as the SRAM access. Read data is registered and returned to the winning lane one cycle later.
- Sits between the lane load/store units and the sram instance (14-bit word address, synchronous write, combinational read).

Parameters:
- NREQ, 4, number of requesting lanes (2..8).
- AW, 14, SRAM word-address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-lane access request; held until granted.
- req_we  in  NREQ  per-lane write enable, qualified by req.
- req_lock  in  NREQ  per-lane lock; keeps the grant on the next cycle (read-modify-write).
- req_addr  in  NREQ*AW  per-lane word address; lane i occupies bits [i*AW +: AW].
- req_wd  in  NREQ*DW  per-lane write data; lane i occupies bits [i*DW +: DW].
- gnt  out  NREQ  one-hot, combinational; access of the granted lane completes at this posedge.
- rvalid  out  NREQ  registered; one-hot pulse, the cycle after a granted read.
- rdata  out  DW  registered read data; valid where rvalid is set.
- sram_addr  out  AW  to sram addr.
- sram_we  out  1  to sram we.
- sram_wd  out  DW  to sram wd.
- sram_rd  in  DW  from sram rd.

Behaviour:
- Reset (clk edge with reset=1):
  - ptr<=0, lock_valid<=0, lock_owner<=0, rvalid<=0, rdata<=0.
  - While reset is high, gnt=0 and sram_we=0 combinationally.
- Arbitration (combinational, each cycle):
  - If lock_valid and req[lock_owner]=1, then gnt=onehot(lock_owner).
  - Else, scan lanes ptr, ptr+1, ... modulo NREQ. The first lane with req=1 wins.
  - If no lane has req=1, gnt=0.
- SRAM mux:
  - With a winner w: sram_addr=req_addr[w], sram_wd=req_wd[w], sram_we=req_we[w].
  - With no winner: sram_we=0, sram_addr=0, sram_wd=0.
- Pointer update (posedge, winner w exists and w was not granted via the lock path): ptr<=(w+1) mod NREQ.
  - Locked grants and idle cycles leave ptr unchanged.
- Lock:
  - At a posedge with winner w: lock_valid<=req_lock[w], lock_owner<=w.
  - With no winner: lock_valid<=0.
  - A locked owner keeps priority only while its req stays high. If req drops, the lock is released in that cycle and normal round-robin applies.
  - Each locked cycle is a full independent access.
- Read return (posedge):
  - Winner w with req_we[w]=0: rdata<=sram_rd, rvalid<=onehot(w). Latency is exactly 1 cycle after gnt.
  - Otherwise: rvalid<=0 and rdata holds its previous value.
- Write: the data is in the SRAM at the same posedge as gnt, so a read granted in the next cycle to the same address returns the new data.
- Requester rules:
  - req, req_we, req_addr and req_wd must be stable from req rise until the posedge where gnt is seen.
  - A lane may issue back-to-back requests; a new request is sampled from the cycle after its grant.
- Fairness: with all NREQ lanes requesting continuously and no lock, each lane is granted exactly once per NREQ cycles.
- Reset mid-operation:
  - A read granted in the reset cycle produces no rvalid, and the lock is dropped.
  - A write presented during reset is not performed (sram_we forced 0).
- Unused lane bits of packed buses are ignored. Behaviour for NREQ outside 2..8 is not supported.

Test Plan:
- Reset, then lane 2 writes 0xDEADBEEF to addr 0x0010. Next cycle lane 2 reads 0x0010 -> gnt=0b0100 both cycles; one cycle after the read gnt, rvalid=0b0100 and rdata=0xDEADBEEF.
- All 4 lanes hold req (reads, addrs 0..3 preloaded 0xA0..0xA3) for 8 cycles -> gnt sequence 0001, 0010, 0100, 1000, 0001, ...; rdata follows 0xA0, 0xA1, 0xA2, 0xA3 one cycle behind the grants.
- Lane 1 holds req_lock for 3 cycles (read 0x20, write 0x20, read 0x20) while lanes 0 and 3 request -> lane 1 is granted 3 consecutive cycles. Then lane 3 wins (ptr=2), then lane 0. The final read returns the written value.
- No requests for 5 cycles -> gnt=0, sram_we=0, rvalid=0, ptr unchanged; a subsequent single request from lane 3 is granted in the same cycle.
- reset asserted in the same cycle as a lane 0 write of 0x1234 to addr 5 and a pending read -> sram_we=0, addr 5 is unchanged, rvalid=0 the next cycle, ptr=0 after reset.
- Lane 0 locked; lane 0 drops req while lane 2 requests -> lane 2 is granted that same cycle and lock_valid clears.
